mem_port_arbiter: RTL and testbench

Shares the single-ported instruction/data memory of the pipelined RISC core between the instruction-fetch stage (read-only port I) and the MEM stage (load/store port D). Data accesses take priority, and a streak limit guarantees fetch progress. The block tracks a configurable memory read latency, returns read data with a one-cycle acknowledge, and honours the core's HALTED condition by blocking new fetch grants.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-ported instruction/data memory between the
// fetch port (I, read-only) and the load/store port (D). D has priority,
// bounded by a streak limit so fetch always makes progress.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction; eligible requests are evaluated each cycle
// ACCESS | memory strobe cycle (mem_en high for exactly this cycle)
// WAIT   | read data in flight; counts down the memory read latency
// DONE   | owner's ack pulses; rdata already registered
module mem_port_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int RD_LAT       = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    input  logic          halted,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int          SW       = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    // WAIT lasts RD_LAT cycles; the counter reaches zero in the cycle
    // where mem_rdata is valid.
    localparam logic [2:0]  LAT_LOAD = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            owner_d;
    logic [2:0]      lat_cnt;
    logic [SW-1:0]   d_streak;
    logic            i_elig;
    logic            d_elig;
    logic            grant_i;
    logic            grant_d;
    logic            rd_last;

    assign i_elig  = i_req & ~halted;
    assign d_elig  = d_req;
    assign rd_last = (state == WAIT) && (lat_cnt == 3'd0);

    // Next-state and grant decision; grants only happen in IDLE.
    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                grant_d = d_elig & (~i_elig | (d_streak != STREAK_MAX));
                grant_i = i_elig & ~grant_d;
                if (grant_i | grant_d) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = mem_we ? DONE : WAIT;
            WAIT:    if (lat_cnt == 3'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered control outputs, ownership, latency timer and streak counter.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            busy     <= 1'b0;
            owner_d  <= 1'b0;
            lat_cnt  <= 3'd0;
            d_streak <= '0;
        end else begin
            mem_en <= grant_i | grant_d;
            if (grant_i | grant_d) begin
                owner_d <= grant_d;
                mem_we  <= grant_d & d_we;
            end else if (state == ACCESS) begin
                mem_we  <= 1'b0;
            end

            if (state == ACCESS) begin
                lat_cnt <= LAT_LOAD;
            end else if ((state == WAIT) && (lat_cnt != 3'd0)) begin
                lat_cnt <= lat_cnt - 3'd1;
            end

            if (grant_i) begin
                d_streak <= '0;
            end else if (grant_d) begin
                d_streak <= i_elig ? d_streak + SW'(1) : '0;
            end

            // owner_d is stable from the grant onward, so it is valid here
            i_ack <= (state_nx == DONE) & ~owner_d;
            d_ack <= (state_nx == DONE) &  owner_d;
            busy  <= (state_nx != IDLE);
        end
    end

    // Address/data capture at the grant and read-data return to the owner only.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_i) begin
                mem_addr  <= i_addr;
                mem_wdata <= '0;
            end

            if (rd_last) begin
                if (owner_d) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1 for the
// main scenarios, one with RD_LAT=3 for the withdrawn-request case.
// Completions are checked by a scoreboard monitor against queued expectations.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        int          port;   // 0 = I, 1 = D
        logic [31:0] data;
        bit          chk;    // compare rdata (loads/fetches only)
    } exp_t;

    logic          clk1 = 1'b0;
    logic          rst  = 1'b0;

    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          halted = 1'b0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    logic          i_req3 = 1'b0;
    logic [AW-1:0] i_addr3 = '0;
    logic          i_ack3;
    logic [DW-1:0] i_rdata3;
    logic          d_req3 = 1'b0;
    logic          d_we3 = 1'b0;
    logic [AW-1:0] d_addr3 = '0;
    logic [DW-1:0] d_wdata3 = '0;
    logic          d_ack3;
    logic [DW-1:0] d_rdata3;
    logic          halted3 = 1'b0;
    logic          mem_en3;
    logic          mem_we3;
    logic [AW-1:0] mem_addr3;
    logic [DW-1:0] mem_wdata3;
    logic [DW-1:0] mem_rdata3;
    logic          busy3;

    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t sb[$];
    exp_t sb3[$];

    always #5 clk1 = ~clk1;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_D_STREAK(4)) u_dut (
        .clk1(clk1), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .halted(halted),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3), .MAX_D_STREAK(4)) u_dut3 (
        .clk1(clk1), .rst(rst),
        .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3), .halted(halted3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
    );

    // Memory contents: a fixed pattern overlaid by whatever has been stored.
    function automatic logic [31:0] init_word(input int a);
        return (a == 0) ? 32'h2801_0078 : (32'hA500_0000 | 32'(a));
    endfunction

    logic          wr_valid [0:1023] = '{default: 1'b0};
    logic [DW-1:0] wr_data  [0:1023];

    function automatic logic [31:0] rd_word(input logic [AW-1:0] a);
        return wr_valid[a] ? wr_data[a] : init_word(int'(a));
    endfunction

    // Memory model, latency 1; outside the valid cycle the bus carries junk.
    logic          p1_v = 1'b0;
    logic [DW-1:0] p1_d = '0;
    always @(posedge clk1) begin
        if (mem_en && mem_we) begin
            wr_valid[mem_addr] <= 1'b1;
            wr_data[mem_addr]  <= mem_wdata;
        end
        p1_v <= mem_en && !mem_we;
        p1_d <= rd_word(mem_addr);
    end
    assign mem_rdata = p1_v ? p1_d : 32'hDEAD_BEEF;

    // Memory model, latency 3 (read-only view of the same contents).
    logic          p3_v [0:2] = '{default: 1'b0};
    logic [DW-1:0] p3_d [0:2];
    always @(posedge clk1) begin
        p3_v[0] <= mem_en3 && !mem_we3;
        p3_d[0] <= rd_word(mem_addr3);
        p3_v[1] <= p3_v[0];
        p3_d[1] <= p3_d[0];
        p3_v[2] <= p3_v[1];
        p3_d[2] <= p3_d[1];
    end
    assign mem_rdata3 = p3_v[2] ? p3_d[2] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_ack(input int which, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            step();
            seen = (which == 0) ? i_ack : ((which == 1) ? d_ack : d_ack3);
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Scoreboard monitor: every ack pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk1);
            if (!rst) begin
                if (i_ack && d_ack) chk("i_ack and d_ack together", 32'd1, 32'd0);
                if (i_ack) begin
                    if (sb.size() == 0) begin
                        chk("unexpected i_ack", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("grant order (I ack)", 32'd0, 32'(e.port));
                        chk("i_rdata", i_rdata, e.data);
                    end
                end
                if (d_ack) begin
                    if (sb.size() == 0) begin
                        chk("unexpected d_ack", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("grant order (D ack)", 32'd1, 32'(e.port));
                        if (e.chk) chk("d_rdata", d_rdata, e.data);
                    end
                end
                if (d_ack3) begin
                    if (sb3.size() == 0) begin
                        chk("unexpected d_ack (lat3)", 32'd1, 32'd0);
                    end else begin
                        e = sb3.pop_front();
                        chk("d_rdata (lat3)", d_rdata3, e.data);
                    end
                end
            end
        end
    end

    initial begin
        int ia, da, acks, ik, dk, nen;
        logic ack_at [1:8];

        // Asynchronous reset values, before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset i_ack", 32'(i_ack), 0);
        chk("reset d_ack", 32'(d_ack), 0);
        chk("reset mem_en", 32'(mem_en), 0);
        chk("reset mem_we", 32'(mem_we), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset mem_addr", 32'(mem_addr), 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset i_rdata", i_rdata, 0);
        chk("reset d_rdata", d_rdata, 0);
        step();
        step();
        rst = 1'b0;

        // Reset during ACCESS of a fetch, then re-grant
        i_req  = 1'b1;
        i_addr = 10'd0;
        sb.push_back('{0, 32'h2801_0078, 1'b1});
        step();
        chk("t1 mem_en in C1", 32'(mem_en), 1);
        rst = 1'b1;
        #1;
        chk("t1 mem_en after rst", 32'(mem_en), 0);
        chk("t1 busy after rst", 32'(busy), 0);
        chk("t1 i_ack after rst", 32'(i_ack), 0);
        step();
        step();
        rst = 1'b0;
        wait_ack(0, "t1 refetch ack timeout");
        i_req = 1'b0;
        step();

        // Single fetch, cycle-accurate
        i_req  = 1'b1;
        i_addr = 10'd0;
        sb.push_back('{0, 32'h2801_0078, 1'b1});
        step();
        chk("t2 C1 mem_en", 32'(mem_en), 1);
        chk("t2 C1 mem_addr", 32'(mem_addr), 0);
        chk("t2 C1 mem_we", 32'(mem_we), 0);
        step();
        chk("t2 C2 mem_en", 32'(mem_en), 0);
        chk("t2 C2 i_ack", 32'(i_ack), 0);
        step();
        chk("t2 C3 i_ack", 32'(i_ack), 1);
        chk("t2 C3 mem_en", 32'(mem_en), 0);
        i_req = 1'b0;
        step();
        chk("t2 C4 i_ack", 32'(i_ack), 0);
        chk("t2 C4 busy", 32'(busy), 0);

        // Store then load of the same word
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'd121;
        d_wdata = 32'd99;
        sb.push_back('{1, 32'd0, 1'b0});
        step();
        chk("t3 C1 mem_en", 32'(mem_en), 1);
        chk("t3 C1 mem_we", 32'(mem_we), 1);
        chk("t3 C1 mem_addr", 32'(mem_addr), 121);
        chk("t3 C1 mem_wdata", mem_wdata, 99);
        step();
        chk("t3 C2 d_ack", 32'(d_ack), 1);
        chk("t3 C2 mem_en", 32'(mem_en), 0);
        d_req = 1'b0;
        step();
        d_we    = 1'b0;
        d_wdata = '0;
        d_req   = 1'b1;
        sb.push_back('{1, 32'd99, 1'b1});
        wait_ack(1, "t3 load ack timeout");
        d_req = 1'b0;
        chk("t3 i_rdata unchanged", i_rdata, 32'h2801_0078);
        step();

        // Contention: expected order D,D,D,D,I,D,D,D,D,I
        ik = 0;
        dk = 0;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                sb.push_back('{0, init_word(8 + ik), 1'b1});
                ik++;
            end else begin
                sb.push_back('{1, init_word(200 + dk), 1'b1});
                dk++;
            end
        end
        i_req  = 1'b1;
        i_addr = 10'd8;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 10'd200;
        acks = 0;
        ik = 0;
        dk = 0;
        for (int n = 0; n < 200 && acks < 10; n++) begin
            step();
            if (d_ack) begin
                dk++;
                d_addr = AW'(200 + dk);
                acks++;
            end
            if (i_ack) begin
                ik++;
                i_addr = AW'(8 + ik);
                acks++;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk("t4 ack count", 32'(acks), 10);
        step();

        // Halt blocks fetch grants but not data accesses
        halted = 1'b1;
        i_req  = 1'b1;
        i_addr = 10'd10;
        d_req  = 1'b1;
        d_addr = 10'd210;
        sb.push_back('{1, init_word(210), 1'b1});
        sb.push_back('{1, init_word(211), 1'b1});
        ia = 0;
        da = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (i_ack) ia++;
            if (d_ack) begin
                da++;
                if (da == 1) d_addr = 10'd211;
                else d_req = 1'b0;
            end
        end
        chk("t5 i_ack while halted", 32'(ia), 0);
        chk("t5 d_ack while halted", 32'(da), 2);
        chk("t5 idle before unhalt", 32'(busy), 0);
        sb.push_back('{0, init_word(10), 1'b1});
        halted = 1'b0;
        step();
        chk("t5 I grant mem_en", 32'(mem_en), 1);
        chk("t5 I grant mem_addr", 32'(mem_addr), 10);
        wait_ack(0, "t5 fetch ack timeout");
        i_req = 1'b0;
        step();

        // Withdrawn request on the RD_LAT=3 instance
        d_req3  = 1'b1;
        d_we3   = 1'b0;
        d_addr3 = 10'd5;
        sb3.push_back('{1, init_word(5), 1'b1});
        nen = 0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 1) begin
                chk("t6 C1 mem_en", 32'(mem_en3), 1);
                d_req3 = 1'b0;
            end
            if (mem_en3) nen++;
            ack_at[n] = d_ack3;
            if (n == 6) chk("t6 C6 idle", 32'(busy3), 0);
        end
        chk("t6 mem_en count", 32'(nen), 1);
        chk("t6 C4 d_ack", 32'(ack_at[4]), 0);
        chk("t6 C5 d_ack", 32'(ack_at[5]), 1);
        chk("t6 C6 d_ack", 32'(ack_at[6]), 0);

        step();
        step();
        chk("scoreboard drained", 32'(sb.size() + sb3.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
